// File: rtl/aes_key_schedule.sv
// AES-128 key expansion engine.
// Streams round keys 0..NR one per cycle after an accepted start and keeps
// every key in a small store so a round controller can fetch any of them later.
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  output logic         key_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int         NKEYS    = NR + 1;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  // AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  // Byte b lives at bit offset (255-b)*8, and ~b is exactly 255-b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  // GF(2^8) multiply by x, used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           rk_valid_q, rk_valid_d;
  logic           done_q, done_d;
  logic           key_ready_q, key_ready_d;
  logic [3:0]     rk_index_q, rk_index_d;
  logic [127:0]   round_key_q, round_key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   store_q [NKEYS];
  logic [127:0]   store_d [NKEYS];

  logic [31:0]    w0, w1, w2, w3, t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;
  logic [3:0]     next_idx;

  // Derive the following round key from the one currently on round_key.
  always_comb begin
    w0       = round_key_q[127:96];
    w1       = round_key_q[95:64];
    w2       = round_key_q[63:32];
    w3       = round_key_q[31:0];
    t_word   = sub_word(rot_word(w3)) ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
    next_idx = rk_index_q + 4'd1;
  end

  // Next-state and output logic for the IDLE/EXPAND controller.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rk_valid_d  = rk_valid_q;
    done_d      = 1'b0;
    key_ready_d = key_ready_q;
    rk_index_d  = rk_index_q;
    round_key_d = round_key_q;
    rcon_d      = rcon_q;
    store_d     = store_q;

    unique case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        rk_valid_d = 1'b0;
        if (start) begin
          round_key_d = key_in;
          rk_index_d  = 4'd0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
          store_d[0]  = key_in;
          key_ready_d = 1'b0;
          rcon_d      = 8'h01;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        if (rk_index_q < LAST_IDX) begin
          round_key_d       = next_key;
          rk_index_d        = next_idx;
          store_d[next_idx] = next_key;
          rcon_d            = xtime(rcon_q);
          if (next_idx == LAST_IDX) begin
            done_d      = 1'b1;
            key_ready_d = 1'b1;
          end
        end else begin
          busy_d     = 1'b0;
          rk_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset clearing outputs and the key store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_index_q  <= 4'd0;
      round_key_q <= '0;
      rcon_q      <= 8'h01;
      store_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rk_valid_q  <= rk_valid_d;
      done_q      <= done_d;
      key_ready_q <= key_ready_d;
      rk_index_q  <= rk_index_d;
      round_key_q <= round_key_d;
      rcon_q      <= rcon_d;
      store_q     <= store_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = rk_valid_q;
  assign done      = done_q;
  assign key_ready = key_ready_q;
  assign rk_index  = rk_index_q;
  assign round_key = round_key_q;
  assign rd_key    = (rd_idx <= LAST_IDX) ? store_q[rd_idx] : '0;

endmodule
